// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: master ids and the default word-address width.
package mem_pkg;

  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } mst_e;

  localparam int MEM_WIDTH_DEFAULT = 13;

endpackage

// File: rtl/mem_arbiter32.sv
// Two-master (instruction fetch / data) arbiter onto one zero-wait-state 32-bit memory port.
// Define MEMARB_RR_EN for round-robin contention; otherwise data always wins.
module mem_arbiter32
  import mem_pkg::*;
#(
  parameter int WIDTH = MEM_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_ready,
  output logic [31:0]      i_rdata,
  output logic             i_rvalid,

  input  logic             d_valid,
  input  logic             d_write,
  input  logic [3:0]       d_wmask,
  input  logic [31:0]      d_wdata,
  input  logic [WIDTH-1:0] d_addr,
  output logic             d_ready,
  output logic [31:0]      d_rdata,
  output logic             d_rvalid,

  output logic             m_valid,
  output logic             m_write,
  output logic [3:0]       m_wmask,
  output logic [31:0]      m_wdata,
  output logic [WIDTH-1:0] m_addr,
  input  logic [31:0]      m_rdata
);

  mst_e last_grant;
  mst_e grant;
  mst_e resp_owner;
  logic resp_read;
  logic req_i;
  logic req_d;
  logic accept;

  // Grant selection and memory port steering, all resolved within the acceptance cycle.
  always_comb begin
    req_i   = i_valid & ~rst;
    req_d   = d_valid & ~rst;
    accept  = req_i | req_d;
    grant   = MST_D;
    if (req_i && req_d) begin
`ifdef MEMARB_RR_EN
      grant = (last_grant == MST_D) ? MST_I : MST_D;
`else
      grant = MST_D;
`endif
    end else if (req_i) begin
      grant = MST_I;
    end

    i_ready = req_i & (grant == MST_I);
    d_ready = req_d & (grant == MST_D);
    m_valid = accept;
    m_addr  = (grant == MST_D) ? d_addr : i_addr;
    m_wdata = d_wdata;
    m_write = 1'b0;
    m_wmask = 4'b0000;
    if (accept && (grant == MST_D)) begin
      m_write = d_write;
      m_wmask = d_wmask;
    end
  end

`ifndef MEMARB_RR_EN
  // Fixed priority ignores the last grant; the register is still kept for observability.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // One-deep response pipeline: remembers who owns the read data returning next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= MST_I;
      resp_read  <= 1'b0;
      resp_owner <= MST_I;
    end else begin
      resp_read <= accept & ~m_write;
      if (accept) begin
        last_grant <= grant;
        resp_owner <= grant;
      end
    end
  end

  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign i_rvalid = resp_read & ~rst & (resp_owner == MST_I);
  assign d_rvalid = resp_read & ~rst & (resp_owner == MST_D);

endmodule

// File: tb/tb_mem_arbiter32.sv
// Self-checking bench for mem_arbiter32: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter32;

  localparam int WIDTH = 13;
  localparam int DEPTH = 1 << WIDTH;

  logic             clk;
  logic             rst;
  logic             i_valid;
  logic [WIDTH-1:0] i_addr;
  logic             i_ready;
  logic [31:0]      i_rdata;
  logic             i_rvalid;
  logic             d_valid;
  logic             d_write;
  logic [3:0]       d_wmask;
  logic [31:0]      d_wdata;
  logic [WIDTH-1:0] d_addr;
  logic             d_ready;
  logic [31:0]      d_rdata;
  logic             d_rvalid;
  logic             m_valid;
  logic             m_write;
  logic [3:0]       m_wmask;
  logic [31:0]      m_wdata;
  logic [WIDTH-1:0] m_addr;
  logic [31:0]      m_rdata;

  int tests;
  int fails;

  mem_arbiter32 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .d_valid(d_valid), .d_write(d_write), .d_wmask(d_wmask), .d_wdata(d_wdata), .d_addr(d_addr),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .m_valid(m_valid), .m_write(m_write), .m_wmask(m_wmask), .m_wdata(m_wdata), .m_addr(m_addr),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait-state synchronous memory attached to the shared port.
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] mem_rdata;
  assign m_rdata = mem_rdata;

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = k * 32'h9E3779B1;
    mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (m_valid) begin
      if (m_write) begin
        for (int b = 0; b < 4; b++)
          if (m_wmask[b]) mem[m_addr][8*b +: 8] = m_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[m_addr];
      end
    end
  end

  // Reference model: memory image, last winner (0=I,1=D) and the response due next cycle.
  logic [31:0] ref_mem [0:DEPTH-1];
  int          model_last;
  bit          exp_pend;
  int          exp_owner;
  logic [31:0] exp_data;

  function automatic int exp_grant(bit iv, bit dv);
    if (iv && dv) begin
`ifdef MEMARB_RR_EN
      return (model_last == 1) ? 0 : 1;
`else
      return 1;
`endif
    end
    if (dv) return 1;
    if (iv) return 0;
    return -1;
  endfunction

  function automatic void model_commit(int g);
    logic [WIDTH-1:0] a;
    logic [31:0]      w;
    exp_pend = 1'b0;
    if (rst) begin
      model_last = 0;
      return;
    end
    if (g < 0) return;
    model_last = g;
    a = (g == 1) ? d_addr : i_addr;
    if (g == 1 && d_write) begin
      w = ref_mem[a];
      for (int b = 0; b < 4; b++)
        if (d_wmask[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
      ref_mem[a] = w;
    end else begin
      exp_pend  = 1'b1;
      exp_owner = g;
      exp_data  = ref_mem[a];
    end
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_write = 1'b0; d_wmask = 4'h0; d_wdata = 32'h0; d_addr = '0;
  endtask

  task automatic test_reset();
    i_valid = 1'b1; d_valid = 1'b1; d_write = 1'b1; d_wmask = 4'hF;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      @(negedge clk);
      tests++; if (i_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_i_ready: got %b want 0", i_ready); end
      tests++; if (d_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_d_ready: got %b want 0", d_ready); end
      tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_valid: got %b want 0", m_valid); end
      tests++; if (m_write !== 1'b0 || m_wmask !== 4'h0) begin fails++; $display("[TB] FAIL reset_m_write: got %b/%h want 0/0", m_write, m_wmask); end
      model_commit(-1);
    end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    tests++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rvalid: got %b%b want 00", i_rvalid, d_rvalid); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL idle_m_valid: got %b want 0", m_valid); end
    model_commit(-1);
  endtask

  task automatic test_ifetch();
    next_cycle();
    d_valid = 1'b1; d_write = 1'b1; d_wmask = 4'hF; d_wdata = 32'h00000013; d_addr = 13'h010;
    @(negedge clk);
    model_commit(exp_grant(i_valid, d_valid));
    next_cycle();
    idle_inputs();
    i_valid = 1'b1; i_addr = 13'h010;
    @(negedge clk);
    tests++; if (i_ready !== 1'b1) begin fails++; $display("[TB] FAIL ifetch_ready: got %b want 1", i_ready); end
    tests++; if (m_valid !== 1'b1 || m_addr !== 13'h010 || m_write !== 1'b0 || m_wmask !== 4'h0) begin
      fails++; $display("[TB] FAIL ifetch_port: got v%b a%h w%b m%h want v1 a010 w0 m0", m_valid, m_addr, m_write, m_wmask); end
    model_commit(exp_grant(i_valid, d_valid));
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h00000013) begin fails++; $display("[TB] FAIL ifetch_resp: got %b/%h want 1/00000013", i_rvalid, i_rdata); end
    tests++; if (d_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL ifetch_d_rvalid: got %b want 0", d_rvalid); end
    model_commit(-1);
  endtask

  task automatic test_write_read();
    logic [31:0] wdat [0:1];
    logic [3:0]  wmsk [0:1];
    wdat[0] = 32'h11223344; wmsk[0] = 4'hF;
    wdat[1] = 32'hAABBCCDD; wmsk[1] = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      idle_inputs();
      d_valid = 1'b1; d_addr = 13'h020;
      if (c < 2) begin d_write = 1'b1; d_wdata = wdat[c]; d_wmask = wmsk[c]; end
      @(negedge clk);
      tests++; if (d_ready !== 1'b1) begin fails++; $display("[TB] FAIL wr_ready%0d: got %b want 1", c, d_ready); end
      tests++; if (d_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL wr_no_rvalid%0d: got %b want 0", c, d_rvalid); end
      model_commit(exp_grant(i_valid, d_valid));
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h11BB33DD) begin fails++; $display("[TB] FAIL raw_data: got %b/%h want 1/11bb33dd", d_rvalid, d_rdata); end
    model_commit(-1);
  endtask

  task automatic test_contention();
    int want_d [0:3];
`ifdef MEMARB_RR_EN
    want_d[0] = 1; want_d[1] = 0; want_d[2] = 1; want_d[3] = 0;
    next_cycle();
    rst = 1'b1; idle_inputs();
    @(negedge clk);
    model_commit(-1);
    next_cycle();
    rst = 1'b0;
`else
    want_d[0] = 1; want_d[1] = 1; want_d[2] = 1; want_d[3] = 1;
`endif
    for (int c = 0; c < 5; c++) begin
      if (c > 0 || !rst) next_cycle();
      i_valid = 1'b1; i_addr = 13'h040;
      d_valid = (c < 4); d_write = 1'b0; d_addr = WIDTH'(c + 5);
      @(negedge clk);
      if (c < 4) begin
        tests++; if (d_ready !== want_d[c][0] || i_ready !== !want_d[c][0]) begin
          fails++; $display("[TB] FAIL contend_grant%0d: got d%b i%b want d%0d", c, d_ready, i_ready, want_d[c]); end
      end else begin
        tests++; if (i_ready !== 1'b1) begin fails++; $display("[TB] FAIL contend_i_after: got %b want 1", i_ready); end
      end
      tests++; if (i_rvalid !== (exp_pend && exp_owner == 0) || d_rvalid !== (exp_pend && exp_owner == 1)) begin
        fails++; $display("[TB] FAIL contend_rvalid%0d: got i%b d%b", c, i_rvalid, d_rvalid); end
      if (exp_pend) begin
        tests++; if (d_rdata !== exp_data) begin fails++; $display("[TB] FAIL contend_rdata%0d: got %h want %h", c, d_rdata, exp_data); end
      end
      model_commit(exp_grant(i_valid, d_valid));
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests++; if (i_rvalid !== 1'b1 || i_rdata !== exp_data) begin fails++; $display("[TB] FAIL contend_last_resp: got %b/%h want 1/%h", i_rvalid, i_rdata, exp_data); end
    model_commit(-1);
  endtask

  task automatic test_reset_mid();
    next_cycle();
    idle_inputs();
    i_valid = 1'b1; i_addr = 13'h007;
    @(negedge clk);
    model_commit(exp_grant(i_valid, d_valid));
    next_cycle();
    rst = 1'b1; d_valid = 1'b1; d_addr = 13'h009;
    @(negedge clk);
    tests++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_rvalid: got %b%b want 00", i_rvalid, d_rvalid); end
    tests++; if (i_ready !== 1'b0 || d_ready !== 1'b0 || m_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL midrst_ready: got i%b d%b m%b want 000", i_ready, d_ready, m_valid); end
    model_commit(-1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    tests++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL postrst_rvalid: got %b%b want 00", i_rvalid, d_rvalid); end
    tests++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin fails++; $display("[TB] FAIL postrst_grant: got d%b i%b want d1 i0", d_ready, i_ready); end
    model_commit(exp_grant(i_valid, d_valid));
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests++; if (d_rvalid !== 1'b1 || d_rdata !== exp_data) begin fails++; $display("[TB] FAIL postrst_resp: got %b/%h want 1/%h", d_rvalid, d_rdata, exp_data); end
    model_commit(-1);
  endtask

  task automatic test_random();
    bit i_hold;
    bit d_hold;
    int g;
    i_hold = 1'b0;
    d_hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      if (!i_hold) begin
        i_valid = 1'($urandom_range(0, 1));
        i_addr  = WIDTH'($urandom_range(0, 31));
      end
      if (!d_hold) begin
        d_valid = 1'($urandom_range(0, 1));
        d_write = 1'($urandom_range(0, 1));
        d_wmask = 4'($urandom);
        d_wdata = $urandom;
        d_addr  = WIDTH'($urandom_range(0, 31));
      end
      @(negedge clk);
      g = exp_grant(i_valid, d_valid);
      tests++; if (i_ready !== (g == 0) || d_ready !== (g == 1) || m_valid !== (g >= 0)) begin
        fails++; $display("[TB] FAIL rnd_grant@%0d: got i%b d%b m%b want grant %0d", n, i_ready, d_ready, m_valid, g); end
      if (g >= 0) begin
        tests++; if (m_addr !== ((g == 1) ? d_addr : i_addr)) begin fails++; $display("[TB] FAIL rnd_addr@%0d: got %h", n, m_addr); end
      end
      tests++; if (m_write !== (g == 1 && d_write) || m_wmask !== ((g == 1) ? d_wmask : 4'h0)) begin
        fails++; $display("[TB] FAIL rnd_wctl@%0d: got w%b m%h", n, m_write, m_wmask); end
      tests++; if (i_rvalid !== (exp_pend && exp_owner == 0) || d_rvalid !== (exp_pend && exp_owner == 1)) begin
        fails++; $display("[TB] FAIL rnd_rvalid@%0d: got i%b d%b want pend%b owner%0d", n, i_rvalid, d_rvalid, exp_pend, exp_owner); end
      if (exp_pend) begin
        tests++; if (((exp_owner == 1) ? d_rdata : i_rdata) !== exp_data) begin
          fails++; $display("[TB] FAIL rnd_rdata@%0d: got %h want %h", n, (exp_owner == 1) ? d_rdata : i_rdata, exp_data); end
      end
      i_hold = i_valid && (g != 0);
      d_hold = d_valid && (g != 1);
      model_commit(g);
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = k * 32'h9E3779B1;
    model_last = 0;
    exp_pend   = 1'b0;
    exp_owner  = 0;
    exp_data   = 32'h0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_ifetch();
    test_write_read();
    test_contention();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
